// File: rtl/sync_ram_ctrl.sv
// rtl/sync_ram_ctrl.sv - synchronous single-port RAM with byte enables, registered read and clear engine
module sync_ram_ctrl #(
    parameter int  DATA_W = 8,
    parameter int  ADDR_W = 16,
    parameter int  DEPTH  = 2**ADDR_W,
    localparam int BE_W   = DATA_W/8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chip_en,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear_req,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid
);

    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;

    logic              in_range;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign in_range = ({1'b0, addr} < DEPTH_X);
    assign old_word = in_range ? mem[addr] : '0;

    // Write-first merge: enabled bytes from data_in, the rest from current content
    always_comb begin
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) merged[8*i +: 8] = data_in[8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = addr;
        mem_wdata  = merged;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (chip_en) begin
                    if (wr_en && in_range) mem_we = 1'b1;
                    if (rd_en) begin
                        rd_valid_d = 1'b1;
                        data_out_d = !in_range ? '0 : (wr_en ? merged : old_word);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage has no reset; contents are zeroed by the clear walk instead
    always_ff @(posedge clk) begin
        if (reset_n && mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign ready    = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// tb/tb_sync_ram_ctrl.sv - directed self-checking bench for sync_ram_ctrl
module tb_sync_ram_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chip_en;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  addr;
    logic [1:0]  be;
    logic [15:0] data_in;
    logic        clear_req;
    logic        ready;
    logic        busy;
    logic [15:0] data_out;
    logic        rd_valid;

    int tests = 0;
    int fails = 0;

    sync_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(12)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .chip_en   (chip_en),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .be        (be),
        .data_in   (data_in),
        .clear_req (clear_req),
        .ready     (ready),
        .busy      (busy),
        .data_out  (data_out),
        .rd_valid  (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        chip_en = 1'b1; wr_en = 1'b1; addr = a; data_in = d; be = b;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
        chip_en = 1'b1; rd_en = 1'b1; addr = a;
        step();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 16'(rd_valid), 16'h1);
        chk({tag, "_data"}, data_out, exp);
    endtask

    task automatic clear_wait(input string tag);
        for (int k = 0; k < 12; k++) begin
            chk({tag, "_busy"}, 16'(busy), 16'h1);
            chk({tag, "_ready_lo"}, 16'(ready), 16'h0);
            step();
        end
        chk({tag, "_ready"}, 16'(ready), 16'h1);
        chk({tag, "_busy_lo"}, 16'(busy), 16'h0);
    endtask

    initial begin
        reset_n = 1'b0; chip_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        addr = '0; be = '0; data_in = '0; clear_req = 1'b0;

        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_busy", 16'(busy), 16'h1);
            chk("rst_ready", 16'(ready), 16'h0);
            chk("rst_dout", data_out, 16'h0000);
            chk("rst_rdv", 16'(rd_valid), 16'h0);
        end
        reset_n = 1'b1;
        rd_en = 1'b1; chip_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("init_busy", 16'(busy), 16'h1);
            chk("init_dout", data_out, 16'h0000);
            step();
            chk("init_rdv", 16'(rd_valid), 16'h0);
        end
        rd_en = 1'b0;
        chk("init_ready", 16'(ready), 16'h1);

        for (int a = 0; a < 12; a++) rd("init_rd", 4'(a), 16'h0000);
        step();
        chk("rdv_pulse", 16'(rd_valid), 16'h0);

        wr(4'd3, 16'hABCD, 2'b11);
        wr(4'd3, 16'h1234, 2'b01);
        rd("be_lo", 4'd3, 16'hAB34);
        wr(4'd3, 16'hFFFF, 2'b00);
        rd("be_none", 4'd3, 16'hAB34);

        wr(4'd5, 16'h1111, 2'b11);
        chip_en = 1'b1; rd_en = 1'b1; wr_en = 1'b1; addr = 4'd5; data_in = 16'h2222; be = 2'b10;
        step();
        rd_en = 1'b0; wr_en = 1'b0;
        chk("rw_valid", 16'(rd_valid), 16'h1);
        chk("rw_merge", data_out, 16'h2211);
        rd("rw_after", 4'd5, 16'h2211);

        clear_req = 1'b1; wr_en = 1'b1; addr = 4'd1; data_in = 16'hFFFF; be = 2'b11;
        step();
        clear_req = 1'b0; wr_en = 1'b0;
        rd_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("clr_busy", 16'(busy), 16'h1);
            step();
            chk("clr_no_rdv", 16'(rd_valid), 16'h0);
        end
        rd_en = 1'b0;
        chk("clr_ready", 16'(ready), 16'h1);
        rd("clr_a1", 4'd1, 16'h0000);
        rd("clr_a3", 4'd3, 16'h0000);
        rd("clr_a5", 4'd5, 16'h0000);

        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("mid_busy", 16'(busy), 16'h1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mid_rst_dout", data_out, 16'h0000);
        clear_wait("restart");

        wr(4'd13, 16'h5555, 2'b11);
        rd("oor", 4'd13, 16'h0000);
        wr(4'd5, 16'h7777, 2'b11);
        rd("pre_ce", 4'd5, 16'h7777);
        chip_en = 1'b0; rd_en = 1'b1; addr = 4'd3;
        step();
        rd_en = 1'b0;
        chk("ce_rdv", 16'(rd_valid), 16'h0);
        chk("ce_hold", data_out, 16'h7777);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_ram_ctrl.md
# sync_ram_ctrl

Parametrised synchronous single-port RAM with byte enables, registered read port and a hardware clear engine. It replaces the fixed 64K x 8 asynchronous RAM with a clocked block that zeroes memory by walking addresses, one word per cycle, instead of in zero time. It reports a ready/busy status and is the memory used by the datapath and test harnesses.

## Interface
- DATA_W, 8: word width in bits; must be a multiple of 8.
- ADDR_W, 16: address width.
- DEPTH, 2**ADDR_W: number of words; 1 <= DEPTH <= 2**ADDR_W.
- BE_W, DATA_W/8: derived byte-enable width; not overridden.

- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- chip_en  in  1  access qualifier; when 0, rd_en/wr_en are ignored.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- addr  in  ADDR_W  word address.
- be  in  BE_W  byte enables for writes; bit i covers data_in[8i+7:8i].
- data_in  in  DATA_W  write data.
- clear_req  in  1  one-cycle pulse that starts a full-memory clear.
- ready  out  1  1 when accesses are accepted (state IDLE).
- busy  out  1  1 while clearing; always equals ~ready.
- data_out  out  DATA_W  registered read data; holds its value between reads.
- rd_valid  out  1  one-cycle pulse; data_out updated this cycle.

## Operation
- States: CLEAR and IDLE.
- Reset (reset_n=0 at an edge): state goes to CLEAR, clear counter=0, data_out=0, rd_valid=0, ready=0, busy=1. Reset has priority over all inputs.
- CLEAR: each cycle writes 0 to mem[counter] and increments the counter.
  - After the write to DEPTH-1, the next state is IDLE.
  - rd_en, wr_en and clear_req are ignored. rd_valid stays 0 and data_out holds.
- IDLE with clear_req=1: go to CLEAR with counter=0. Any rd/wr in the same cycle is discarded and no rd_valid is produced (clear has priority).
- IDLE, chip_en=1, wr_en=1: for each i with be[i]=1, mem[addr] byte i <= data_in byte i. Bytes with be[i]=0 are unchanged; be=0 writes nothing.
- IDLE, chip_en=1, rd_en=1: data_out <= mem[addr] and rd_valid <= 1.
- rd_en and wr_en together (same address, write-first): data_out returns the merged word.
  - Bytes with be=1 come from data_in; the rest come from the old content.
  - Memory is also updated.
- chip_en=0: no access, rd_valid=0, data_out holds. There is no tri-state output.
- Out of range (addr >= DEPTH): writes are dropped. Reads return 0 with rd_valid=1.
- Clear counter is ADDR_W bits wide. It never exceeds DEPTH-1, so it does not wrap.

## Timing
- Read latency 1: a request sampled at edge k gives data_out/rd_valid valid after edge k, for one cycle.
- Back-to-back reads allowed every cycle, so rd_valid can stay high continuously.
- Write takes effect at the sampling edge. A read of the same address in the next cycle returns the new data.
- Clear duration: exactly DEPTH cycles in CLEAR. ready rises after the edge that writes DEPTH-1.
- After reset_n deasserts: DEPTH cycles pass before the first access is accepted. Reset in the middle of a clear restarts it from address 0.
- ready/busy are registered state outputs, with no combinational path from the inputs.

## Test plan
Parameters: DATA_W=16, ADDR_W=4, DEPTH=12.

- Reset and initial clear: hold reset_n=0 for 2 cycles, then release.
  - During reset and the 12 cycles after: busy=1, data_out=0.
  - Then ready=1. Reads of addresses 0..11 each return 0x0000 with rd_valid one cycle after the request.
- Byte enables:
  - Write addr 3 with data 0xABCD, be=11.
  - Write addr 3 with data 0x1234, be=01.
  - Read addr 3 returns 0xAB34. A write with be=00 leaves it 0xAB34.
- Simultaneous read/write:
  - Memory holds addr 5 = 0x1111.
  - Issue rd+wr to addr 5 with data 0x2222, be=10: data_out=0x2211 next cycle.
  - A later read of addr 5 returns 0x2211.
- Clear priority and ignore:
  - Pulse clear_req together with a write of 0xFFFF to addr 1: the write is dropped and busy=1 for 12 cycles.
  - rd_en during the clear produces no rd_valid. Afterwards addr 1 reads 0.
- Reset mid-clear and out of range:
  - Assert reset_n=0 at clear cycle 6: the clear restarts and takes a full 12 cycles.
  - Then write 0x5555 to addr 13: read of addr 13 returns 0 with rd_valid=1.
  - chip_en=0 with rd_en=1 gives no rd_valid and data_out held.
